sim_mmio_ctrl: RTL and testbench

Parametrised memory-mapped simulation/test controller on the CPU data port, beside ram_dp. It replaces ad-hoc halt/signature decoding at top level with a synthesizable register block:
- halt with pass/fail code
- signature window registers
- buffered console output with ready/valid drain
- free-running cycle counter
- optional watchdog timeout

Top-level testbench code only observes its outputs.

---
 rtl/sim_mmio_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/sim_mmio_ctrl.sv | 144 ++++++++++++++
 tb/tb_sim_mmio_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_mmio_pkg.sv
// Shared definitions for the simulation/test MMIO controller:
// register indices, window size and console status bit positions.
package sim_mmio_pkg;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [IDX_W-1:0] {
        REG_HALT      = 3'd0,
        REG_SIG_BEGIN = 3'd1,
        REG_SIG_END   = 3'd2,
        REG_CONSOLE   = 3'd3,
        REG_CYCLE_LO  = 3'd4,
        REG_CYCLE_HI  = 3'd5,
        REG_RSVD6     = 3'd6,
        REG_RSVD7     = 3'd7
    } reg_idx_e;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with ready/valid pop side; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    input  logic             ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign valid    = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = valid && ready;
    assign do_push  = push && (!full || do_pop);
    // Head is forced to zero when empty so stale storage never leaks out.
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sim_mmio_ctrl.sv
// Memory-mapped simulation controller: halt/pass/fail, signature window,
// buffered console output, free-running cycle counter and optional watchdog.
module sim_mmio_ctrl
    import sim_mmio_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE      = 32'h2000_0000,
    parameter int              CON_DEPTH = 8,
    parameter int              TIMEOUT   = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic            sel,
    output logic [XLEN-1:0] load_data,
    output logic            halt,
    output logic            pass,
    output logic [XLEN-1:0] fail_code,
    output logic            timeout,
    output logic [XLEN-1:0] sig_begin,
    output logic [XLEN-1:0] sig_end,
    output logic [7:0]      con_data,
    output logic            con_valid,
    input  logic            con_ready,
    output logic [63:0]     cycle
);

    localparam int              ALIGN   = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0] WIN_LEN = XLEN'(NUM_REGS * (XLEN / 8));
    localparam logic [63:0]     WD_LAST = 64'(TIMEOUT) - 64'd1;

    logic [XLEN-1:0] off;
    reg_idx_e        idx;
    logic            wr_en;
    logic            halt_wr;
    logic            wd_fire;
    logic            con_push;
    logic            con_full;
    logic            overflow;
    logic [XLEN-1:0] rd_val;

    // Addresses below BASE wrap to a huge offset and fail the range test.
    assign off   = address - BASE;
    assign sel   = (off < WIN_LEN) && (off[ALIGN-1:0] == '0);
    assign idx   = reg_idx_e'(off[ALIGN+IDX_W-1:ALIGN]);
    assign wr_en = store && sel;

    // Even values are not halt requests; once halted the code is frozen.
    assign halt_wr  = wr_en && (idx == REG_HALT) && store_data[0] && !halt;
    assign wd_fire  = (TIMEOUT != 0) && !halt && (cycle == WD_LAST);
    assign con_push = wr_en && (idx == REG_CONSOLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            halt      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            timeout   <= 1'b0;
        end else if (halt_wr) begin
            halt      <= 1'b1;
            pass      <= (store_data == XLEN'(1));
            fail_code <= (store_data == XLEN'(1)) ? '0 : (store_data >> 1);
        end else if (wd_fire) begin
            halt      <= 1'b1;
            pass      <= 1'b0;
            fail_code <= '0;
            timeout   <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_begin <= '0;
            sig_end   <= '0;
        end else if (wr_en) begin
            if (idx == REG_SIG_BEGIN) begin
                sig_begin <= store_data;
            end
            if (idx == REG_SIG_END) begin
                sig_end <= store_data;
            end
        end
    end

    // A push into a full FIFO is lost unless the consumer drains a slot this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (con_push && con_full && !(con_valid && con_ready)) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + 64'd1;
        end
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_HALT:      rd_val = {fail_code[XLEN-3:0], pass, halt};
            REG_SIG_BEGIN: rd_val = sig_begin;
            REG_SIG_END:   rd_val = sig_end;
            REG_CONSOLE: begin
                rd_val[STAT_EMPTY]    = !con_valid;
                rd_val[STAT_FULL]     = con_full;
                rd_val[STAT_OVERFLOW] = overflow;
            end
            REG_CYCLE_LO:  rd_val = cycle[XLEN-1:0];
            REG_CYCLE_HI:  rd_val = (XLEN == 32) ? XLEN'(cycle >> 32) : '0;
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            load_data <= '0;
        end else if (load && sel) begin
            load_data <= rd_val;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (con_push),
        .push_data (store_data[7:0]),
        .full      (con_full),
        .pop_data  (con_data),
        .valid     (con_valid),
        .ready     (con_ready)
    );

endmodule

// File: tb/tb_sim_mmio_ctrl.sv
// Directed bench for sim_mmio_ctrl; read data and console bytes are checked
// by a monitor against scoreboard queues filled when stimulus is issued.
module tb_sim_mmio_ctrl;

    localparam int          XLEN = 32;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic        sel;
    logic [31:0] load_data;
    logic        halt;
    logic        pass;
    logic [31:0] fail_code;
    logic        timeout;
    logic [31:0] sig_begin;
    logic [31:0] sig_end;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic [63:0] cycle;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  con_q[$];
    logic        rd_pending = 1'b0;

    sim_mmio_ctrl #(
        .XLEN      (XLEN),
        .BASE      (BASE),
        .CON_DEPTH (8),
        .TIMEOUT   (100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .store      (store),
        .address    (address),
        .store_data (store_data),
        .sel        (sel),
        .load_data  (load_data),
        .halt       (halt),
        .pass       (pass),
        .fail_code  (fail_code),
        .timeout    (timeout),
        .sig_begin  (sig_begin),
        .sig_end    (sig_end),
        .con_data   (con_data),
        .con_valid  (con_valid),
        .con_ready  (con_ready),
        .cycle      (cycle)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares registered read data one edge after a load, and each
    // console byte at the moment the handshake is presented.
    always @(negedge clock) begin
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL load_data: got 0x%0h expected no read", load_data);
            end else begin
                check_output("load_data", load_data, rd_q.pop_front());
            end
        end
        rd_pending = load && !reset;
        if (!reset && con_valid && con_ready) begin
            if (con_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL con_data: got 0x%0h expected no byte", con_data);
            end else begin
                check_output("con_data", con_data, con_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic apply_store(input logic [31:0] addr, input logic [31:0] data);
        address    = addr;
        store_data = data;
        store      = 1'b1;
        step();
        store      = 1'b0;
    endtask

    task automatic apply_load(input logic [31:0] addr, input logic [31:0] expected);
        address = addr;
        load    = 1'b1;
        rd_q.push_back(expected);
        step();
        load    = 1'b0;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        load      = 1'b0;
        store     = 1'b0;
        con_ready = 1'b0;
        step();
        step();
        con_q.delete();
        reset     = 1'b0;
    endtask

    task automatic check_sel(input logic [31:0] addr, input logic expected);
        address = addr;
        #1;
        check_output("sel", 64'(sel), 64'(expected));
    endtask

    initial begin
        // Reset values
        apply_reset();
        check_output("rst_halt", 64'(halt), 0);
        check_output("rst_pass", 64'(pass), 0);
        check_output("rst_fail_code", 64'(fail_code), 0);
        check_output("rst_timeout", 64'(timeout), 0);
        check_output("rst_sig_begin", 64'(sig_begin), 0);
        check_output("rst_con_valid", 64'(con_valid), 0);
        check_output("rst_cycle", cycle, 0);
        check_output("rst_load_data", 64'(load_data), 0);

        // Window decode boundaries
        check_sel(BASE, 1'b1);
        check_sel(BASE + 32'd28, 1'b1);
        check_sel(BASE + 32'd32, 1'b0);
        check_sel(BASE - 32'd4, 1'b0);
        check_sel(BASE + 32'd2, 1'b0);

        // Pass halt, then a later halt write is ignored
        apply_store(BASE, 32'h1);
        check_output("pass_halt", 64'(halt), 1);
        check_output("pass_pass", 64'(pass), 1);
        check_output("pass_fail_code", 64'(fail_code), 0);
        apply_load(BASE, 32'h3);
        apply_store(BASE, 32'h7);
        check_output("sticky_pass", 64'(pass), 1);
        check_output("sticky_fail_code", 64'(fail_code), 0);

        // Even write ignored, odd write fails with code
        apply_reset();
        apply_store(BASE, 32'h4);
        check_output("even_halt", 64'(halt), 0);
        apply_store(BASE, 32'h0000_000B);
        check_output("fail_halt", 64'(halt), 1);
        check_output("fail_pass", 64'(pass), 0);
        check_output("fail_code", 64'(fail_code), 5);
        apply_load(BASE, 32'h15);

        // Signature registers, same-cycle load/store, misaligned and reserved
        apply_store(BASE + 32'd4, 32'h8000_1000);
        apply_store(BASE + 32'd8, 32'h8000_1200);
        check_output("sig_begin", 64'(sig_begin), 64'h8000_1000);
        check_output("sig_end", 64'(sig_end), 64'h8000_1200);
        apply_load(BASE + 32'd8, 32'h8000_1200);
        address    = BASE + 32'd4;
        store_data = 32'h0000_1234;
        store      = 1'b1;
        load       = 1'b1;
        rd_q.push_back(32'h8000_1000);
        step();
        store      = 1'b0;
        load       = 1'b0;
        check_output("sig_begin_new", 64'(sig_begin), 64'h1234);
        apply_store(BASE + 32'd5, 32'hDEAD);
        check_output("misaligned_ignored", 64'(sig_begin), 64'h1234);
        apply_store(BASE + 32'd28, 32'hFFFF_FFFF);
        apply_load(BASE + 32'd28, 32'h0);

        // Console overflow then drain
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) con_q.push_back(8'(8'h41 + i));
            apply_store(BASE + 32'd12, 32'(32'h41 + i));
        end
        check_output("con_valid_full", 64'(con_valid), 1);
        apply_load(BASE + 32'd12, 32'h6);
        con_ready = 1'b1;
        repeat (8) step();
        check_output("con_drained", 64'(con_valid), 0);
        apply_load(BASE + 32'd12, 32'h5);

        // Push and pop on the same edge while full
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            con_q.push_back(8'(8'h61 + i));
            apply_store(BASE + 32'd12, 32'(32'h61 + i));
        end
        apply_load(BASE + 32'd12, 32'h2);
        address    = BASE + 32'd12;
        store_data = 32'h50;
        store      = 1'b1;
        con_ready  = 1'b1;
        con_q.push_back(8'h50);
        step();
        store      = 1'b0;
        con_ready  = 1'b0;
        apply_load(BASE + 32'd12, 32'h2);
        con_ready = 1'b1;
        repeat (8) step();
        check_output("con_drained2", 64'(con_valid), 0);

        // Watchdog fires on edge 100
        apply_reset();
        repeat (99) step();
        check_output("wd_before_halt", 64'(halt), 0);
        check_output("wd_before_cycle", cycle, 99);
        step();
        check_output("wd_halt", 64'(halt), 1);
        check_output("wd_timeout", 64'(timeout), 1);
        check_output("wd_pass", 64'(pass), 0);
        check_output("wd_fail_code", 64'(fail_code), 0);
        apply_load(BASE + 32'd16, 32'd100);
        apply_load(BASE + 32'd20, 32'd0);

        // Halt write on the watchdog edge wins
        apply_reset();
        repeat (99) step();
        apply_store(BASE, 32'h1);
        check_output("wdw_halt", 64'(halt), 1);
        check_output("wdw_pass", 64'(pass), 1);
        check_output("wdw_timeout", 64'(timeout), 0);

        // Mid-run reset clears everything, including buffered console bytes
        apply_store(BASE + 32'd12, 32'h77);
        apply_store(BASE + 32'd4, 32'hABCD);
        apply_load(BASE, 32'h3);
        reset = 1'b1;
        step();
        check_output("mid_halt", 64'(halt), 0);
        check_output("mid_pass", 64'(pass), 0);
        check_output("mid_sig_begin", 64'(sig_begin), 0);
        check_output("mid_con_valid", 64'(con_valid), 0);
        check_output("mid_con_data", 64'(con_data), 0);
        check_output("mid_cycle", cycle, 0);
        check_output("mid_load_data", 64'(load_data), 0);
        reset = 1'b0;
        step();

        check_output("rd_q_empty", 64'(rd_q.size()), 0);
        check_output("con_q_empty", 64'(con_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
